// File: rtl/regfile_mp_if.sv
// Bus between the ID/WB stages and the multi-port register file:
// three read ports, two write ports, one scoreboard allocation port.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] readimport1;
  logic [ADDR_W-1:0] readimport2;
  logic [ADDR_W-1:0] readimport3;
  logic [DATA_W-1:0] regfile_out1;
  logic [DATA_W-1:0] regfile_out2;
  logic [DATA_W-1:0] regfile_out3;
  logic              busy_out1;
  logic              busy_out2;
  logic              busy_out3;
  logic [ADDR_W-1:0] writeimport0;
  logic [DATA_W-1:0] Writedata0;
  logic              regWr0;
  logic [ADDR_W-1:0] writeimport1;
  logic [DATA_W-1:0] Writedata1;
  logic              regWr1;
  logic [ADDR_W-1:0] alloc_addr;
  logic              alloc_en;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output readimport1, readimport2, readimport3,
    output writeimport0, Writedata0, regWr0,
    output writeimport1, Writedata1, regWr1,
    output alloc_addr, alloc_en,
    input  regfile_out1, regfile_out2, regfile_out3,
    input  busy_out1, busy_out2, busy_out3, busy_count
  );

  modport slave (
    input  readimport1, readimport2, readimport3,
    input  writeimport0, Writedata0, regWr0,
    input  writeimport1, Writedata1, regWr1,
    input  alloc_addr, alloc_en,
    output regfile_out1, regfile_out2, regfile_out3,
    output busy_out1, busy_out2, busy_out3, busy_count
  );
endinterface

// File: rtl/regfile_mp.sv
// Dual-write, triple-read register file with write-to-read bypass and a
// per-register busy scoreboard for the hazard unit.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [CNT_W-1:0]  count_next;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              alloc_ok;

  function automatic logic is_gated(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Port 1 is the younger instruction, so its bypass is checked first.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              w0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              w1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1,
    input logic [DATA_W-1:0] stored
  );
    if (is_gated(addr))          return '0;
    else if (w1 && (a1 == addr)) return d1;
    else if (w0 && (a0 == addr)) return d0;
    else                         return stored;
  endfunction

  function automatic logic busy_port(
    input logic [ADDR_W-1:0] addr,
    input logic              w0,
    input logic [ADDR_W-1:0] a0,
    input logic              w1,
    input logic [ADDR_W-1:0] a1,
    input logic              al,
    input logic [ADDR_W-1:0] aa,
    input logic              stored
  );
    if (is_gated(addr)) return 1'b0;
    else if (((w0 && (a0 == addr)) || (w1 && (a1 == addr))) && !(al && (aa == addr))) return 1'b0;
    else return stored;
  endfunction

  assign wr0_ok   = bus.regWr0   && !is_gated(bus.writeimport0);
  assign wr1_ok   = bus.regWr1   && !is_gated(bus.writeimport1);
  assign alloc_ok = bus.alloc_en && !is_gated(bus.alloc_addr);

  assign bus.regfile_out1 = read_port(bus.readimport1, wr0_ok, bus.writeimport0, bus.Writedata0,
                                      wr1_ok, bus.writeimport1, bus.Writedata1, regs[bus.readimport1]);
  assign bus.regfile_out2 = read_port(bus.readimport2, wr0_ok, bus.writeimport0, bus.Writedata0,
                                      wr1_ok, bus.writeimport1, bus.Writedata1, regs[bus.readimport2]);
  assign bus.regfile_out3 = read_port(bus.readimport3, wr0_ok, bus.writeimport0, bus.Writedata0,
                                      wr1_ok, bus.writeimport1, bus.Writedata1, regs[bus.readimport3]);

  assign bus.busy_out1 = busy_port(bus.readimport1, wr0_ok, bus.writeimport0, wr1_ok, bus.writeimport1,
                                   alloc_ok, bus.alloc_addr, busy[bus.readimport1]);
  assign bus.busy_out2 = busy_port(bus.readimport2, wr0_ok, bus.writeimport0, wr1_ok, bus.writeimport1,
                                   alloc_ok, bus.alloc_addr, busy[bus.readimport2]);
  assign bus.busy_out3 = busy_port(bus.readimport3, wr0_ok, bus.writeimport0, wr1_ok, bus.writeimport1,
                                   alloc_ok, bus.alloc_addr, busy[bus.readimport3]);

  // A new producer supersedes the old one, so alloc beats a same-cycle clear.
  always_comb begin
    busy_next  = busy;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_ok && (bus.alloc_addr == ADDR_W'(i)))
        busy_next[i] = 1'b1;
      else if ((wr0_ok && (bus.writeimport0 == ADDR_W'(i))) ||
               (wr1_ok && (bus.writeimport1 == ADDR_W'(i))))
        busy_next[i] = 1'b0;
      count_next = count_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      bus.busy_count <= '0;
    end else begin
      busy           <= busy_next;
      bus.busy_count <= count_next;
    end
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[bus.writeimport0] <= bus.Writedata0;
      if (wr1_ok) regs[bus.writeimport1] <= bus.Writedata1;
    end
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, negedge-write register file. Writes on posedge, with write-to-read bypass.
- Two write ports support a dual-issue writeback stage. Three read ports feed decode.
- A per-register busy scoreboard lets the hazard unit stall on in-flight producers.
- Sits between ID (reads, alloc) and WB (writes) of the pipelined CPU.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
readimport1  input  ADDR_W  read port 1 address
readimport2  input  ADDR_W  read port 2 address
readimport3  input  ADDR_W  read port 3 address
regfile_out1  output  DATA_W  read port 1 data (combinational)
regfile_out2  output  DATA_W  read port 2 data
regfile_out3  output  DATA_W  read port 3 data
busy_out1  output  1  scoreboard bit of readimport1 after bypass
busy_out2  output  1  scoreboard bit of readimport2 after bypass
busy_out3  output  1  scoreboard bit of readimport3 after bypass
writeimport0  input  ADDR_W  write port 0 address
Writedata0  input  DATA_W  write port 0 data
regWr0  input  1  write port 0 enable
writeimport1  input  ADDR_W  write port 1 address
Writedata1  input  DATA_W  write port 1 data
regWr1  input  1  write port 1 enable
alloc_addr  input  ADDR_W  destination register being issued
alloc_en  input  1  mark alloc_addr busy
busy_count  output  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- Reset
  - rst high at a rising edge: all registers := 0, all busy bits := 0, busy_count := 0.
  - Writes and alloc in that cycle are discarded.
  - Reset mid-operation aborts all pending state. Scoreboard is empty the next cycle.
- Write
  - At a rising edge with rst low: if regWrN and address is not gated by ZERO_REG, register[writeimportN] := WritedataN.
  - Same address on both ports, both enabled: port 1 wins (younger instruction). Port 0 data is dropped.
- Read
  - Purely combinational, zero latency.
  - Output priority: (a) address 0 with ZERO_REG=1 -> 0; (b) matches writeimport1 with regWr1 -> Writedata1; (c) matches writeimport0 with regWr0 -> Writedata0; (d) stored register.
  - Bypass applies even while rst is high. The hazard unit masks it.
- Scoreboard, per register i, next state at rising edge:
  - rst -> 0.
  - Else alloc_en and alloc_addr==i -> 1. Alloc beats a same-cycle write clear, because a new producer supersedes the old one.
  - Else a qualifying write to i on either port -> 0.
  - Else hold.
  - Alloc of register 0 with ZERO_REG=1 is ignored.
- busy_outN
  - Equals busy[readimportN], forced 0 when a same-cycle qualifying write targets readimportN and there is no same-cycle alloc of it.
  - Forced 0 for register 0 when ZERO_REG=1.
- busy_count
  - Registered popcount of the next-state busy vector. It always equals the number of 1 bits in busy one cycle after the update.
  - Range 0..2**ADDR_W. Width prevents wrap at all registers busy.
- Write to a non-busy register is legal: data updates, busy stays 0.
- No $display in synthesizable body. Debug dumps belong in the bench.

Test Plan:
- Reset clear: preload R5=0xDEADBEEF, assert rst 1 cycle -> regfile_out1(addr 5)=0, busy_count=0.
- Bypass: regWr0=1, writeimport0=3, Writedata0=0x12345678, readimport2=3 in same cycle -> regfile_out2=0x12345678 before the edge; after the edge, stored value is 0x12345678.
- Write collision: both ports write R7 (port0 0x1111, port1 0x2222) -> R7=0x2222 after the edge; readimport1=7 bypasses 0x2222 during the cycle.
- Zero register: ZERO_REG=1, write R0=0xFFFFFFFF, alloc R0 -> regfile_out1(0)=0, busy_out1=0, busy_count unchanged.
- Scoreboard race: alloc R9 at cycle n; at cycle n+2, alloc R9 plus regWr1 to R9 -> busy_out stays 1, busy_count stays 1; at n+3, write R9 alone -> busy 0, busy_count 0.
- Full scoreboard: ZERO_REG=0, alloc all 32 registers on consecutive cycles -> busy_count reaches 32 with no wrap; rst in the middle of the sequence -> busy_count=0 the next cycle.
